pattern_pwm_bank: RTL and testbench

PATTERN_PWM_BANK -- requirements
Module: pattern_pwm_bank

---
 rtl/pattern_pwm_bank.sv | 192 +++++++++++++++++++
 tb/tb_pattern_pwm_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_pwm_bank.sv
// Bank of independent pattern-PWM channels: each shifts a byte-programmed pattern out MSB first,
// stretching every bit by a duty count, separating repetitions by a gap and pulsing valid when finished.
module pattern_pwm_bank #(
   parameter int _NUM_CHANNELS = 4,
   parameter int _PAT_WIDTH    = 32,
   parameter int _GAP_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [2:0]               wr_ch,
   input  logic [3:0]               wr_addr,
   input  logic [7:0]               wr_data,
   input  logic [_NUM_CHANNELS-1:0] start,
   input  logic [_NUM_CHANNELS-1:0] abort,
   output logic [_NUM_CHANNELS-1:0] pwm_out,
   output logic [_NUM_CHANNELS-1:0] busy,
   output logic [_NUM_CHANNELS-1:0] valid
);

   localparam int PW = _PAT_WIDTH;
   localparam int NB = _PAT_WIDTH / 8;
   localparam int BW = $clog2(_PAT_WIDTH);
   localparam int GW = _GAP_WIDTH;
   localparam logic [BW-1:0] BIT_LAST = BW'(_PAT_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;

   for (genvar ch = 0; ch < _NUM_CHANNELS; ch++) begin : gCh
      state_e          state_q, state_d;
      logic [1:0]      shCtrl_q, shCtrl_d;
      logic [7:0]      shDuty_q, shDuty_d;
      logic [15:0]     shGap_q, shGap_d;
      logic [7:0]      shPulse_q, shPulse_d;
      logic [PW-1:0]   shPat_q, shPat_d;
      logic [7:0]      actDuty_q, actDuty_d;
      logic [GW-1:0]   actGap_q, actGap_d;
      logic [7:0]      actPulse_q, actPulse_d;
      logic            actInv_q, actInv_d;
      logic [PW-1:0]   actPat_q, actPat_d;
      logic [PW-1:0]   patSh_q, patSh_d;
      logic [BW-1:0]   bitCnt_q, bitCnt_d;
      logic [7:0]      dutyCnt_q, dutyCnt_d;
      logic [GW-1:0]   gapCnt_q, gapCnt_d;
      logic [7:0]      repCnt_q, repCnt_d;
      logic            pwm_q, pwm_d;
      logic [7:0]      dutyLast;
      logic [7:0]      repNext;

      // Shadow registers are always writable; only a start copies them into the active set.
      always_comb begin
         shCtrl_d  = shCtrl_q;
         shDuty_d  = shDuty_q;
         shGap_d   = shGap_q;
         shPulse_d = shPulse_q;
         shPat_d   = shPat_q;
         if (wr_en && (wr_ch == 3'(ch))) begin
            case (wr_addr)
               4'd0: shCtrl_d = wr_data[1:0];
               4'd1: shDuty_d = wr_data;
               4'd2: shGap_d[7:0] = wr_data;
               4'd3: shGap_d[15:8] = wr_data;
               4'd4: shPulse_d = wr_data;
               default: begin
                  for (int k = 0; k < NB; k++) begin
                     if (wr_addr == 4'(5 + k)) shPat_d[8*k +: 8] = wr_data;
                  end
               end
            endcase
         end
      end

      assign dutyLast = (actDuty_q == 8'd0) ? 8'd0 : actDuty_q - 8'd1;
      assign repNext  = repCnt_q + 8'd1;

      // Pattern sequencer; abort overrides every transition, and the output bit is registered
      // from the next-state values so the first pattern bit shows in the cycle after start.
      always_comb begin
         state_d    = state_q;
         actDuty_d  = actDuty_q;
         actGap_d   = actGap_q;
         actPulse_d = actPulse_q;
         actInv_d   = actInv_q;
         actPat_d   = actPat_q;
         patSh_d    = patSh_q;
         bitCnt_d   = bitCnt_q;
         dutyCnt_d  = dutyCnt_q;
         gapCnt_d   = gapCnt_q;
         repCnt_d   = repCnt_q;
         case (state_q)
            IDLE: begin
               if (start[ch] && !abort[ch] && shCtrl_q[0]) begin
                  actDuty_d  = shDuty_q;
                  actGap_d   = GW'(shGap_q);
                  actPulse_d = shPulse_q;
                  actInv_d   = shCtrl_q[1];
                  actPat_d   = shPat_q;
                  patSh_d    = shPat_q;
                  bitCnt_d   = '0;
                  dutyCnt_d  = '0;
                  repCnt_d   = '0;
                  state_d    = SHIFT;
               end
            end
            SHIFT: begin
               if (dutyCnt_q != dutyLast) begin
                  dutyCnt_d = dutyCnt_q + 8'd1;
               end else begin
                  dutyCnt_d = '0;
                  if (bitCnt_q != BIT_LAST) begin
                     bitCnt_d = bitCnt_q + BW'(1);
                     patSh_d  = patSh_q << 1;
                  end else begin
                     repCnt_d = repNext;
                     if (actGap_q != '0) begin
                        gapCnt_d = actGap_q;
                        state_d  = GAP;
                     end else if ((actPulse_q != 8'd0) && (repNext == actPulse_q)) begin
                        state_d = DONE;
                     end else begin
                        patSh_d  = actPat_q;
                        bitCnt_d = '0;
                     end
                  end
               end
            end
            GAP: begin
               if (gapCnt_q != GW'(1)) begin
                  gapCnt_d = gapCnt_q - GW'(1);
               end else if ((actPulse_q != 8'd0) && (repCnt_q == actPulse_q)) begin
                  state_d = DONE;
               end else begin
                  patSh_d   = actPat_q;
                  bitCnt_d  = '0;
                  dutyCnt_d = '0;
                  state_d   = SHIFT;
               end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
         if (abort[ch]) state_d = IDLE;
         pwm_d = (state_d == SHIFT) ? (patSh_d[PW-1] ^ actInv_d) : actInv_d;
      end

      // All shadow, active and sequencing state clears on reset, including enable and invert.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q    <= IDLE;
            shCtrl_q   <= '0;
            shDuty_q   <= '0;
            shGap_q    <= '0;
            shPulse_q  <= '0;
            shPat_q    <= '0;
            actDuty_q  <= '0;
            actGap_q   <= '0;
            actPulse_q <= '0;
            actInv_q   <= 1'b0;
            actPat_q   <= '0;
            patSh_q    <= '0;
            bitCnt_q   <= '0;
            dutyCnt_q  <= '0;
            gapCnt_q   <= '0;
            repCnt_q   <= '0;
            pwm_q      <= 1'b0;
         end else begin
            state_q    <= state_d;
            shCtrl_q   <= shCtrl_d;
            shDuty_q   <= shDuty_d;
            shGap_q    <= shGap_d;
            shPulse_q  <= shPulse_d;
            shPat_q    <= shPat_d;
            actDuty_q  <= actDuty_d;
            actGap_q   <= actGap_d;
            actPulse_q <= actPulse_d;
            actInv_q   <= actInv_d;
            actPat_q   <= actPat_d;
            patSh_q    <= patSh_d;
            bitCnt_q   <= bitCnt_d;
            dutyCnt_q  <= dutyCnt_d;
            gapCnt_q   <= gapCnt_d;
            repCnt_q   <= repCnt_d;
            pwm_q      <= pwm_d;
         end
      end

      assign pwm_out[ch] = pwm_q;
      assign busy[ch]    = (state_q == SHIFT) || (state_q == GAP);
      assign valid[ch]   = (state_q == DONE);
   end

endmodule

// File: tb/tb_pattern_pwm_bank.sv
// Directed bench for pattern_pwm_bank with 8-bit patterns; expected waveforms are hand-derived
// from the programmed pattern, duty, gap and repetition count.
module tb_pattern_pwm_bank;

   localparam int NCH = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wr_en;
   logic [2:0]     wr_ch;
   logic [3:0]     wr_addr;
   logic [7:0]     wr_data;
   logic [NCH-1:0] start;
   logic [NCH-1:0] abort;
   logic [NCH-1:0] pwm_out;
   logic [NCH-1:0] busy;
   logic [NCH-1:0] valid;

   int errors = 0;
   int checks = 0;

   pattern_pwm_bank #(
      ._NUM_CHANNELS(NCH),
      ._PAT_WIDTH   (8),
      ._GAP_WIDTH   (16)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .start  (start),
      .abort  (abort),
      .pwm_out(pwm_out),
      .busy   (busy),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] ch, input logic [3:0] addr, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_ch   = ch;
      wr_addr = addr;
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic configure(input logic [2:0] ch, input logic [7:0] ctrl, input logic [7:0] duty,
                            input logic [15:0] gap, input logic [7:0] pulse, input logic [7:0] pat);
      applyStimulus(ch, 4'd0, ctrl);
      applyStimulus(ch, 4'd1, duty);
      applyStimulus(ch, 4'd2, gap[7:0]);
      applyStimulus(ch, 4'd3, gap[15:8]);
      applyStimulus(ch, 4'd4, pulse);
      applyStimulus(ch, 4'd5, pat);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] exp16;
      logic [7:0]  pat8;
      logic        expBit;
      int          vcount;

      rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
      start = '0; abort = '0;
      repeat (3) tick();
      checkOutput("reset pwm", 32'(pwm_out), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset valid", 32'(valid), 32'h0);
      rst_n = 1'b1;
      tick();

      // ch0: A5, duty 2, gap 3, one repetition
      configure(3'd0, 8'h01, 8'd2, 16'd3, 8'd1, 8'hA5);
      exp16 = 16'hCC33;
      start = 4'b0001; tick(); start = '0;
      for (int k = 0; k < 19; k++) begin
         expBit = (k < 16) ? exp16[15-k] : 1'b0;
         checkOutput($sformatf("t1 pwm c%0d", k + 1), 32'(pwm_out[0]), 32'(expBit));
         checkOutput($sformatf("t1 busy c%0d", k + 1), 32'(busy[0]), 32'h1);
         checkOutput($sformatf("t1 valid c%0d", k + 1), 32'(valid[0]), 32'h0);
         tick();
      end
      checkOutput("t1 valid c20", 32'(valid[0]), 32'h1);
      checkOutput("t1 busy c20", 32'(busy[0]), 32'h0);
      checkOutput("t1 pwm c20", 32'(pwm_out[0]), 32'h0);
      tick();
      checkOutput("t1 valid c21", 32'(valid[0]), 32'h0);

      // ch1: 81, duty 1, gap 0, three back-to-back repetitions
      configure(3'd1, 8'h01, 8'd1, 16'd0, 8'd3, 8'h81);
      pat8 = 8'h81;
      vcount = 0;
      start = 4'b0010; tick(); start = '0;
      for (int k = 0; k < 24; k++) begin
         checkOutput($sformatf("t2 pwm c%0d", k + 1), 32'(pwm_out[1]), 32'(pat8[7 - (k % 8)]));
         checkOutput($sformatf("t2 busy c%0d", k + 1), 32'(busy[1]), 32'h1);
         if (valid[1]) vcount++;
         tick();
      end
      checkOutput("t2 valid end", 32'(valid[1]), 32'h1);
      checkOutput("t2 busy end", 32'(busy[1]), 32'h0);
      tick();
      checkOutput("t2 valid after", 32'(valid[1]), 32'h0);
      checkOutput("t2 early valids", 32'(vcount), 32'h0);

      // ch2: 3C inverted, duty 1, gap 2, endless until abort
      configure(3'd2, 8'h03, 8'd1, 16'd2, 8'd0, 8'h3C);
      pat8 = 8'h3C;
      vcount = 0;
      start = 4'b0100; tick(); start = '0;
      for (int k = 0; k < 100; k++) begin
         expBit = ((k % 10) < 8) ? (pat8[7 - (k % 10)] ^ 1'b1) : 1'b1;
         checkOutput($sformatf("t3 pwm c%0d", k + 1), 32'(pwm_out[2]), 32'(expBit));
         checkOutput($sformatf("t3 busy c%0d", k + 1), 32'(busy[2]), 32'h1);
         if (valid[2]) vcount++;
         tick();
      end
      abort = 4'b0100; tick(); abort = '0;
      checkOutput("t3 abort pwm", 32'(pwm_out[2]), 32'h1);
      checkOutput("t3 abort busy", 32'(busy[2]), 32'h0);
      checkOutput("t3 abort valid", 32'(valid[2]), 32'h0);
      repeat (3) begin
         if (valid[2]) vcount++;
         tick();
      end
      checkOutput("t3 valid count", 32'(vcount), 32'h0);

      // ch0 again: duty rewritten to 5 mid-run only takes effect on the next start
      exp16 = 16'hCC33;
      start = 4'b0001; tick(); start = '0;
      for (int k = 0; k < 19; k++) begin
         if (k == 2) begin
            wr_en = 1'b1; wr_ch = 3'd0; wr_addr = 4'd1; wr_data = 8'd5;
         end
         if (k == 3) wr_en = 1'b0;
         expBit = (k < 16) ? exp16[15-k] : 1'b0;
         checkOutput($sformatf("t4 pwm c%0d", k + 1), 32'(pwm_out[0]), 32'(expBit));
         tick();
      end
      checkOutput("t4 valid c20", 32'(valid[0]), 32'h1);
      tick();
      start = 4'b0001; tick(); start = '0;
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("t4 duty5 c%0d", k + 1), 32'(pwm_out[0]), (k < 5) ? 32'h1 : 32'h0);
         tick();
      end
      abort = 4'b0001; tick(); abort = '0;
      checkOutput("t4 abort busy", 32'(busy[0]), 32'h0);

      // ch3: start+abort together, start while disabled, write to out-of-range channel
      configure(3'd3, 8'h01, 8'd1, 16'd0, 8'd0, 8'hF0);
      start = 4'b1000; abort = 4'b1000; tick(); start = '0; abort = '0;
      checkOutput("t5 start+abort busy", 32'(busy[3]), 32'h0);
      checkOutput("t5 start+abort pwm", 32'(pwm_out[3]), 32'h0);
      tick();
      checkOutput("t5 start+abort busy2", 32'(busy[3]), 32'h0);
      applyStimulus(3'd3, 4'd0, 8'h00);
      applyStimulus(3'd7, 4'd0, 8'h01);
      start = 4'b1000; tick(); start = '0;
      checkOutput("t5 disabled busy", 32'(busy[3]), 32'h0);
      tick();
      checkOutput("t5 disabled busy2", 32'(busy[3]), 32'h0);

      // All channels together, then reset mid-run
      applyStimulus(3'd3, 4'd0, 8'h01);
      start = 4'hF; tick(); start = '0;
      checkOutput("t6 align pwm c1", 32'(pwm_out), 32'hF);
      checkOutput("t6 align busy", 32'(busy), 32'hF);
      tick();
      checkOutput("t6 align pwm c2", 32'(pwm_out), 32'hD);
      tick();
      checkOutput("t6 align pwm c3", 32'(pwm_out), 32'h9);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("t6 reset pwm", 32'(pwm_out), 32'h0);
      checkOutput("t6 reset busy", 32'(busy), 32'h0);
      checkOutput("t6 reset valid", 32'(valid), 32'h0);
      #2 rst_n = 1'b1;
      tick();
      start = 4'b0001; tick(); start = '0;
      checkOutput("t6 no enable busy", 32'(busy[0]), 32'h0);
      tick();
      checkOutput("t6 no enable busy2", 32'(busy[0]), 32'h0);
      applyStimulus(3'd0, 4'd0, 8'h01);
      start = 4'b0001; tick(); start = '0;
      checkOutput("t6 reenabled busy", 32'(busy[0]), 32'h1);
      checkOutput("t6 cleared pat pwm", 32'(pwm_out[0]), 32'h0);
      abort = 4'b0001; tick(); abort = '0;
      checkOutput("t6 final busy", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
